// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate enable, horizontal/vertical phase FSMs,
// active-low syncs, active-area enables, active-pixel coordinates and frame-start pulse.
`timescale 1ns/1ps
module vga_timing_ctrl #(
  parameter int unsigned PX_DIV   = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       i_sclr,
  output logic       o_px_clk,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_frame_start
);

  localparam int unsigned DivW = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PX_DIV - 1);

  // Last count value of each phase; counters restart at 0 on phase entry.
  localparam logic [9:0] HActLast  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] HFpLast   = 10'(H_FP - 1);
  localparam logic [9:0] HSyncLast = 10'(H_SYNC - 1);
  localparam logic [9:0] HBpLast   = 10'(H_BP - 1);
  localparam logic [9:0] VActLast  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VFpLast   = 10'(V_FP - 1);
  localparam logic [9:0] VSyncLast = 10'(V_SYNC - 1);
  localparam logic [9:0] VBpLast   = 10'(V_BP - 1);

  typedef enum logic [1:0] {StAct, StFp, StSync, StBp} phase_e;

  logic [DivW-1:0] r_div;
  phase_e          r_h_state, w_h_state_d;
  phase_e          r_v_state, w_v_state_d;
  logic [9:0]      r_hcnt, w_hcnt_d;
  logic [9:0]      r_vcnt, w_vcnt_d;
  logic            w_tick;
  logic            w_line_end;
  logic            w_frame_wrap;
  logic            r_hsync, r_vsync, r_haddr_en, r_vaddr_en, r_frame_start;
  logic [9:0]      r_hidx;
  logic [8:0]      r_vidx;

  // Pixel-rate divider; clear overrides any pending wrap.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_div <= '0;
    end else if (r_div == DivLast) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  assign o_px_clk = (r_div == DivLast);
  assign w_tick   = o_px_clk;

  // Horizontal phase sequencing, advanced once per pixel tick.
  always_comb begin
    w_h_state_d = r_h_state;
    w_hcnt_d    = r_hcnt;
    w_line_end  = 1'b0;
    if (w_tick) begin
      w_hcnt_d = r_hcnt + 10'd1;
      case (r_h_state)
        StAct:  if (r_hcnt == HActLast)  begin w_h_state_d = StFp;   w_hcnt_d = '0; end
        StFp:   if (r_hcnt == HFpLast)   begin w_h_state_d = StSync; w_hcnt_d = '0; end
        StSync: if (r_hcnt == HSyncLast) begin w_h_state_d = StBp;   w_hcnt_d = '0; end
        StBp: begin
          if (r_hcnt == HBpLast) begin
            w_h_state_d = StAct;
            w_hcnt_d    = '0;
            w_line_end  = 1'b1;
          end
        end
        default: begin
          w_h_state_d = StAct;
          w_hcnt_d    = '0;
        end
      endcase
    end
  end

  // Vertical phase sequencing, advanced only at end of line.
  always_comb begin
    w_v_state_d  = r_v_state;
    w_vcnt_d     = r_vcnt;
    w_frame_wrap = 1'b0;
    if (w_line_end) begin
      w_vcnt_d = r_vcnt + 10'd1;
      case (r_v_state)
        StAct:  if (r_vcnt == VActLast)  begin w_v_state_d = StFp;   w_vcnt_d = '0; end
        StFp:   if (r_vcnt == VFpLast)   begin w_v_state_d = StSync; w_vcnt_d = '0; end
        StSync: if (r_vcnt == VSyncLast) begin w_v_state_d = StBp;   w_vcnt_d = '0; end
        StBp: begin
          if (r_vcnt == VBpLast) begin
            w_v_state_d  = StAct;
            w_vcnt_d     = '0;
            w_frame_wrap = 1'b1;
          end
        end
        default: begin
          w_v_state_d = StAct;
          w_vcnt_d    = '0;
        end
      endcase
    end
  end

  // State and output registers; outputs are decoded from next state so they land
  // on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_h_state     <= StAct;
      r_v_state     <= StAct;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_haddr_en    <= 1'b1;
      r_vaddr_en    <= 1'b1;
      r_hidx        <= '0;
      r_vidx        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_state     <= w_h_state_d;
      r_v_state     <= w_v_state_d;
      r_hcnt        <= w_hcnt_d;
      r_vcnt        <= w_vcnt_d;
      r_hsync       <= (w_h_state_d != StSync);
      r_vsync       <= (w_v_state_d != StSync);
      r_haddr_en    <= (w_h_state_d == StAct);
      r_vaddr_en    <= (w_v_state_d == StAct);
      r_hidx        <= (w_h_state_d == StAct) ? w_hcnt_d : 10'd0;
      r_vidx        <= (w_v_state_d == StAct) ? w_vcnt_d[8:0] : 9'd0;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_haddr_en    = r_haddr_en;
  assign o_vaddr_en    = r_vaddr_en;
  assign o_hidx        = r_hidx;
  assign o_vidx        = r_vidx;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances (default, tiny, mid-size timing) checked
// every clk against a raster-position model derived from clocks elapsed since clear.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       px;
    logic       hsync;
    logic       vsync;
    logic       hen;
    logic       ven;
    logic [9:0] hidx;
    logic [8:0] vidx;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sclr_d = 1'b1, sclr_s = 1'b1, sclr_m = 1'b1;
  int unsigned n_vec = 0, n_err = 0;

  // Default 640x480 instance.
  logic d_px, d_hs, d_vs, d_hen, d_ven, d_fs;
  logic [9:0] d_hidx;
  logic [8:0] d_vidx;
  vga_timing_ctrl u_dut_d (
    .clk(clk), .i_sclr(sclr_d), .o_px_clk(d_px), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_haddr_en(d_hen), .o_vaddr_en(d_ven), .o_hidx(d_hidx), .o_vidx(d_vidx),
    .o_frame_start(d_fs)
  );

  // Tiny instance: line 8 ticks, frame 6 lines.
  logic s_px, s_hs, s_vs, s_hen, s_ven, s_fs;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;
  vga_timing_ctrl #(
    .PX_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_s (
    .clk(clk), .i_sclr(sclr_s), .o_px_clk(s_px), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_haddr_en(s_hen), .o_vaddr_en(s_ven), .o_hidx(s_hidx), .o_vidx(s_vidx),
    .o_frame_start(s_fs)
  );

  // Mid-size instance: line 32 ticks, frame 19 lines, divide by 3.
  logic m_px, m_hs, m_vs, m_hen, m_ven, m_fs;
  logic [9:0] m_hidx;
  logic [8:0] m_vidx;
  vga_timing_ctrl #(
    .PX_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4)
  ) u_dut_m (
    .clk(clk), .i_sclr(sclr_m), .o_px_clk(m_px), .o_hsync(m_hs), .o_vsync(m_vs),
    .o_haddr_en(m_hen), .o_vaddr_en(m_ven), .o_hidx(m_hidx), .o_vidx(m_vidx),
    .o_frame_start(m_fs)
  );

  // Expected outputs after c clk edges since the last clear edge.
  function automatic exp_t model(input int unsigned pxd, input int unsigned ha,
                                 input int unsigned hf, input int unsigned hs,
                                 input int unsigned hb, input int unsigned va,
                                 input int unsigned vf, input int unsigned vs,
                                 input int unsigned vb, input longint c);
    exp_t   e;
    longint t, line_t, frame_t, p, col, ln;
    t       = c / pxd;
    line_t  = ha + hf + hs + hb;
    frame_t = line_t * (va + vf + vs + vb);
    p       = t % frame_t;
    col     = p % line_t;
    ln      = p / line_t;
    e.px    = ((c % pxd) == pxd - 1);
    e.hen   = (col < ha);
    e.hidx  = e.hen ? 10'(col) : 10'd0;
    e.hsync = !((col >= ha + hf) && (col < ha + hf + hs));
    e.ven   = (ln < va);
    e.vidx  = e.ven ? 9'(ln) : 9'd0;
    e.vsync = !((ln >= va + vf) && (ln < va + vf + vs));
    e.fs    = (c > 0) && ((c % pxd) == 0) && ((t % frame_t) == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".px_clk"}, 32'(a.px), 32'(e.px));
    chk({tag, ".hsync"}, 32'(a.hsync), 32'(e.hsync));
    chk({tag, ".vsync"}, 32'(a.vsync), 32'(e.vsync));
    chk({tag, ".haddr_en"}, 32'(a.hen), 32'(e.hen));
    chk({tag, ".vaddr_en"}, 32'(a.ven), 32'(e.ven));
    chk({tag, ".hidx"}, 32'(a.hidx), 32'(e.hidx));
    chk({tag, ".vidx"}, 32'(a.vidx), 32'(e.vidx));
    chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
  endtask

  // Clocks elapsed since each instance's last clear edge.
  longint c_d = 0, c_s = 0, c_m = 0;
  bit     v_d = 1'b0, v_s = 1'b0, v_m = 1'b0;

  always @(posedge clk) begin
    if (sclr_d) begin c_d <= 0; v_d <= 1'b1; end else c_d <= c_d + 1;
    if (sclr_s) begin c_s <= 0; v_s <= 1'b1; end else c_s <= c_s + 1;
    if (sclr_m) begin c_m <= 0; v_m <= 1'b1; end else c_m <= c_m + 1;
  end

  // Every-cycle comparison, sampled on the inactive edge.
  always @(negedge clk) begin
    if (v_d) cmp("dflt", {d_px, d_hs, d_vs, d_hen, d_ven, d_hidx, d_vidx, d_fs},
                 model(4, 640, 16, 96, 48, 480, 10, 2, 33, c_d));
    if (v_s) cmp("tiny", {s_px, s_hs, s_vs, s_hen, s_ven, s_hidx, s_vidx, s_fs},
                 model(2, 4, 1, 2, 1, 3, 1, 1, 1, c_s));
    if (v_m) cmp("mid", {m_px, m_hs, m_vs, m_hen, m_ven, m_hidx, m_vidx, m_fs},
                 model(3, 20, 3, 5, 4, 10, 2, 3, 4, c_m));
  end

  function automatic exp_t mdef(input longint c);
    return model(4, 640, 16, 96, 48, 480, 10, 2, 33, c);
  endfunction

  initial begin
    exp_t e;

    // Hand-computed anchors for the model at default timing.
    e = mdef(0);       chk("pin.c0.hidx", 32'(e.hidx), 0);
    chk("pin.c0.fs", 32'(e.fs), 0);
    e = mdef(3);       chk("pin.c3.px", 32'(e.px), 1);
    e = mdef(4);       chk("pin.c4.px", 32'(e.px), 0);
    e = mdef(2559);    chk("pin.c2559.hidx", 32'(e.hidx), 639);
    e = mdef(2560);    chk("pin.c2560.hen", 32'(e.hen), 0);
    e = mdef(2623);    chk("pin.c2623.hsync", 32'(e.hsync), 1);
    e = mdef(2624);    chk("pin.c2624.hsync", 32'(e.hsync), 0);
    e = mdef(3007);    chk("pin.c3007.hsync", 32'(e.hsync), 0);
    e = mdef(3008);    chk("pin.c3008.hsync", 32'(e.hsync), 1);
    e = mdef(3200);    chk("pin.line1.vidx", 32'(e.vidx), 1);
    e = mdef(3200 * 480); chk("pin.line480.ven", 32'(e.ven), 0);
    e = mdef(3200 * 490); chk("pin.line490.vsync", 32'(e.vsync), 0);
    e = mdef(3200 * 492); chk("pin.line492.vsync", 32'(e.vsync), 1);
    e = mdef(1679996); chk("pin.pre_frame.fs", 32'(e.fs), 0);
    e = mdef(1680000); chk("pin.frame.fs", 32'(e.fs), 1);
    e = mdef(1680001); chk("pin.post_frame.fs", 32'(e.fs), 0);
    e = model(2, 4, 1, 2, 1, 3, 1, 1, 1, 96); chk("pin.tiny_frame.fs", 32'(e.fs), 1);

    // Clear 3 clks, then release.
    repeat (3) @(negedge clk);
    chk("rst.hsync", 32'(d_hs), 1);
    chk("rst.hen", 32'(d_hen), 1);
    chk("rst.hidx", 32'(d_hidx), 0);
    chk("rst.px", 32'(d_px), 0);
    sclr_d = 1'b0; sclr_s = 1'b0; sclr_m = 1'b0;
    @(negedge clk); chk("rel1.px", 32'(d_px), 0);
    repeat (2) @(negedge clk); chk("rel3.px", 32'(d_px), 1);
    repeat (2620) @(negedge clk); chk("dut.c2623.hsync", 32'(d_hs), 1);
    @(negedge clk); chk("dut.c2624.hsync", 32'(d_hs), 0);

    // Run over two more lines of default timing, many tiny and mid frames.
    repeat (6000) @(negedge clk);

    // One-clk clear mid-frame on the mid instance.
    sclr_m = 1'b1;
    @(negedge clk);
    sclr_m = 1'b0;
    chk("midclr.hidx", 32'(m_hidx), 0);
    chk("midclr.vidx", 32'(m_vidx), 0);
    chk("midclr.ven", 32'(m_ven), 1);
    chk("midclr.vsync", 32'(m_vs), 1);
    chk("midclr.fs", 32'(m_fs), 0);

    // Random clear pulses of random length against random run lengths.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(50, 600)) @(negedge clk);
      sclr_d = 1'($urandom_range(0, 1));
      sclr_s = 1'($urandom_range(0, 1));
      sclr_m = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      sclr_d = 1'b0; sclr_s = 1'b0; sclr_m = 1'b0;
    end
    repeat (400) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
